flit_pkt_decoder: RTL and testbench

FLIT_PKT_DECODER -- requirements
Module: flit_pkt_decoder

---
 rtl/flit_pkt_decoder_pkg.sv | 37 +++
 rtl/flit_pkt_decoder_if.sv | 39 +++
 rtl/flit_pkt_decoder_body_buffer.sv | 61 ++++++
 rtl/flit_pkt_decoder.sv | 172 +++++++++++++++++
 tb/tb_flit_pkt_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flit_pkt_decoder_pkg.sv
// rtl/flit_pkt_decoder_pkg.sv - flit type codes, FSM encoding and parameter legality rules
//
// Package noc_flit_pkg, imported by the decoder, its body buffer and its interface users.
// Contents:
//   flit_type_e       : HEAD=00, BODY=01, TAIL=10, RSVD=11
//   ST_IDLE/COLLECT/OUTPUT : decoder state encoding
//   *_ok functions    : elaboration-time legality rules for the decoder parameters

package noc_flit_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b00,
    FLIT_BODY = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  // A packet needs at least an address flit and one data flit.
  function automatic bit body_count_ok(input int nb);
    return nb >= 2;
  endfunction

  // Address flit carries the address above the read/write flag and one spare bit.
  function automatic bit addr_width_ok(input int fw, input int aw);
    return aw == fw - 2;
  endfunction

  // Each data flit contributes its upper fw-1 bits to the write data.
  function automatic bit data_width_ok(input int fw, input int nb, input int dw);
    return (dw >= 1) && (dw <= (nb - 1) * (fw - 1));
  endfunction

endpackage

// File: rtl/flit_pkt_decoder_if.sv
// rtl/flit_pkt_decoder_if.sv - flit-side and request-side signals of the packet decoder
//
// slave  : decoder side (takes flits, drives decoded requests and o_err)
// master : producer/consumer side (drives flits and i_ready)
// Signals:
//   i_flit_valid / o_flit_ready : flit handshake
//   i_flit_type [1:0], i_flit [FLIT_WIDTH-1:0] : flit type and payload
//   o_valid / i_ready           : decoded-request handshake
//   o_address, o_wdata, o_read_write_enable : decoded request
//   o_err                       : one-cycle protocol-error pulse

interface flit_pkt_decoder_if #(
  parameter int FLIT_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);

  logic                  i_flit_valid;
  logic                  o_flit_ready;
  logic [1:0]            i_flit_type;
  logic [FLIT_WIDTH-1:0] i_flit;
  logic                  o_valid;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] o_address;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_read_write_enable;
  logic                  o_err;

  modport slave (
    input  i_flit_valid, i_flit_type, i_flit, i_ready,
    output o_flit_ready, o_valid, o_address, o_wdata, o_read_write_enable, o_err
  );

  modport master (
    output i_flit_valid, i_flit_type, i_flit, i_ready,
    input  o_flit_ready, o_valid, o_address, o_wdata, o_read_write_enable, o_err
  );

endinterface

// File: rtl/flit_pkt_decoder_body_buffer.sv
// rtl/flit_pkt_decoder_body_buffer.sv - body flit store with fill count (module flit_body_buffer)
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears count and storage)
//   clr        : restart filling at index 0 (has priority over wr_en)
//   wr_en      : store wr_data at index count and advance count (ignored when full)
//   wr_data    : flit payload to store
//   count      : number of flits stored, 0..NUM_BODY_FLITS
//   body_flat  : all stored flits, flit i at [i*FLIT_WIDTH +: FLIT_WIDTH]

module flit_body_buffer
  import noc_flit_pkg::*;
#(
  parameter int FLIT_WIDTH     = 16,
  parameter int NUM_BODY_FLITS = 4,
  parameter int CNT_W          = $clog2(NUM_BODY_FLITS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [FLIT_WIDTH-1:0]                wr_data,
  output logic [CNT_W-1:0]                     count,
  output logic [NUM_BODY_FLITS*FLIT_WIDTH-1:0] body_flat
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BODY_FLITS);

  logic [CNT_W-1:0]                     count_q, count_d;
  logic [NUM_BODY_FLITS*FLIT_WIDTH-1:0] body_q, body_d;

  always_comb begin
    count_d = count_q;
    body_d  = body_q;
    if (clr) begin
      // Stale contents are left in place; they are overwritten before they are read.
      count_d = '0;
    end else if (wr_en && (count_q < FULL_CNT)) begin
      for (int i = 0; i < NUM_BODY_FLITS; i++) begin
        if (count_q == CNT_W'(i)) begin
          body_d[i*FLIT_WIDTH +: FLIT_WIDTH] = wr_data;
        end
      end
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      body_q  <= '0;
    end else begin
      count_q <= count_d;
      body_q  <= body_d;
    end
  end

  assign count     = count_q;
  assign body_flat = body_q;

endmodule

// File: rtl/flit_pkt_decoder.sv
// rtl/flit_pkt_decoder.sv - decodes HEAD/BODY.../TAIL flit packets into address/write-data requests
//
// Optional feature macro: FLIT_PKT_DECODER_PARITY_EN (TAIL bit 0 must equal XOR of all body bits).
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : flit_pkt_decoder_if.slave (flit handshake, decoded request handshake, o_err)
// A packet is HEAD, NUM_BODY_FLITS BODY flits, TAIL. Body 0 carries address and the
// read/write flag; bodies 1..N-1 carry write data in their upper FLIT_WIDTH-1 bits.

module flit_pkt_decoder
  import noc_flit_pkg::*;
#(
  parameter int FLIT_WIDTH     = 16,
  parameter int NUM_BODY_FLITS = 4,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32
) (
  input  logic              clk,
  input  logic              rst,
  flit_pkt_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_BODY_FLITS + 1);
  localparam int CAT_W = (NUM_BODY_FLITS - 1) * (FLIT_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BODY_FLITS);

  if (!body_count_ok(NUM_BODY_FLITS) || !addr_width_ok(FLIT_WIDTH, ADDR_WIDTH) ||
      !data_width_ok(FLIT_WIDTH, NUM_BODY_FLITS, DATA_WIDTH)) begin : g_bad_cfg
    $error("flit_pkt_decoder: illegal FLIT_WIDTH/NUM_BODY_FLITS/ADDR_WIDTH/DATA_WIDTH");
  end

  logic [1:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;

  logic                                 flit_ready;
  logic                                 accept;
  logic                                 buf_clr;
  logic                                 buf_wr;
  logic [CNT_W-1:0]                     count;
  logic [NUM_BODY_FLITS*FLIT_WIDTH-1:0] body_flat;
  logic [CAT_W-1:0]                     cat;
  logic                                 parity_ok;
  logic                                 unused_ok;

  flit_body_buffer #(
    .FLIT_WIDTH     (FLIT_WIDTH),
    .NUM_BODY_FLITS (NUM_BODY_FLITS),
    .CNT_W          (CNT_W)
  ) u_body_buffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_data   (bus.i_flit),
    .count     (count),
    .body_flat (body_flat)
  );

  assign flit_ready = (state_q != ST_OUTPUT);
  assign accept     = bus.i_flit_valid && flit_ready;

  // Data bodies packed MSB first: body1 occupies the top FLIT_WIDTH-1 bits.
  for (genvar i = 1; i < NUM_BODY_FLITS; i++) begin : g_cat
    assign cat[CAT_W-1-(i-1)*(FLIT_WIDTH-1) -: FLIT_WIDTH-1] =
      body_flat[i*FLIT_WIDTH+1 +: FLIT_WIDTH-1];
  end

`ifdef FLIT_PKT_DECODER_PARITY_EN
  assign parity_ok = (bus.i_flit[0] == (^body_flat));
`else
  assign parity_ok = 1'b1;
`endif

  // Flit bit 0 of data bodies and the low end of the concatenation are intentionally unused.
  assign unused_ok = ^{body_flat, cat};

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.i_flit_type == FLIT_HEAD) begin
            state_d = ST_COLLECT;
            buf_clr = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          case (bus.i_flit_type)
            FLIT_HEAD: begin
              // Resync: abandon the partial packet and start over on this head.
              err_d   = 1'b1;
              buf_clr = 1'b1;
            end
            FLIT_BODY: begin
              if (count < FULL_CNT) begin
                buf_wr = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
            FLIT_TAIL: begin
              if ((count == FULL_CNT) && parity_ok) begin
                state_d = ST_OUTPUT;
                addr_d  = body_flat[FLIT_WIDTH-1:2];
                rw_d    = body_flat[1];
                wdata_d = cat[CAT_W-1 -: DATA_WIDTH];
              end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      ST_OUTPUT: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  assign bus.o_flit_ready        = flit_ready;
  assign bus.o_valid             = (state_q == ST_OUTPUT);
  assign bus.o_address           = addr_q;
  assign bus.o_wdata             = wdata_q;
  assign bus.o_read_write_enable = rw_q;
  assign bus.o_err               = err_q;

endmodule

// File: tb/tb_flit_pkt_decoder.sv
// tb/tb_flit_pkt_decoder.sv - self-checking bench for flit_pkt_decoder with a packet-level model

module tb_flit_pkt_decoder;

  localparam int FW    = 16;
  localparam int NB    = 4;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int CAT_W = (NB - 1) * (FW - 1);

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rw;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flit_pkt_decoder_if #(.FLIT_WIDTH(FW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  flit_pkt_decoder #(
    .FLIT_WIDTH     (FW),
    .NUM_BODY_FLITS (NB),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          err_cycles = 0;
  req_t        got_q[$];
  req_t        exp_q[$];
  logic [FW-1:0] pkt [NB];

  // Reference: address is body0 without its two low bits, flag is body0 bit 1;
  // write data is the top DW bits of the data bodies with bit 0 dropped, body1 first.
  function automatic req_t model_decode();
    req_t        r;
    logic [63:0] acc;
    acc    = 64'd0;
    r.addr = AW'(pkt[0] >> 2);
    r.rw   = pkt[0][1];
    for (int k = 1; k < NB; k++) begin
      acc = (acc << (FW - 1)) | 64'(pkt[k] >> 1);
    end
    r.wdata = DW'(acc >> (CAT_W - DW));
    return r;
  endfunction

  function automatic logic model_parity();
    logic p;
    p = 1'b0;
    for (int k = 0; k < NB; k++) p = p ^ (^pkt[k]);
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_err) err_cycles++;
      if (bus.o_valid && bus.i_ready)
        got_q.push_back({bus.o_address, bus.o_wdata, bus.o_read_write_enable});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [1:0] t, input logic [FW-1:0] d);
    int waited;
    waited = 0;
    bus.i_flit_valid = 1'b1;
    bus.i_flit_type  = t;
    bus.i_flit       = d;
    @(negedge clk);
    while (!bus.o_flit_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 40) begin
      n_checks++;
      n_errors++;
      $display("FAIL flit_accept_timeout: o_flit_ready=%b after %0d cycles, required 1", bus.o_flit_ready, waited);
    end
    @(posedge clk);
    #1;
    bus.i_flit_valid = 1'b0;
    bus.i_flit_type  = 2'($urandom);
    bus.i_flit       = FW'($urandom);
  endtask

  task automatic send_pkt(input bit bad_parity);
    logic [FW-1:0] tail;
    tail = FW'($urandom);
`ifdef FLIT_PKT_DECODER_PARITY_EN
    tail[0] = model_parity() ^ bad_parity;
`else
    tail[0] = tail[0] ^ bad_parity;
`endif
    send_flit(T_HEAD, FW'($urandom));
    for (int k = 0; k < NB; k++) send_flit(T_BODY, pkt[k]);
    send_flit(T_TAIL, tail);
  endtask

  task automatic rand_pkt();
    for (int k = 0; k < NB; k++) pkt[k] = FW'($urandom);
  endtask

  task automatic check_one_req(input string name, input req_t exp);
    // only used to compare the single captured request of a scenario
    n_checks++;
    if (got_q.size() != 1) begin
      n_errors++;
      $display("FAIL %s_count: got %0d requests, required 1", name, got_q.size());
    end else if (got_q[0] !== exp) begin
      n_errors++;
      $display("FAIL %s_req: got addr=%h wdata=%h rw=%b, required addr=%h wdata=%h rw=%b",
               name, got_q[0].addr, got_q[0].wdata, got_q[0].rw, exp.addr, exp.wdata, exp.rw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_flit_valid = 1'b0;
    bus.i_flit_type  = T_HEAD;
    bus.i_flit       = '0;
    bus.i_ready      = 1'b1;
    tick(3);
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_o_valid: got %b, required 0", bus.o_valid); end
    n_checks++; if (bus.o_err !== 1'b0) begin n_errors++; $display("FAIL reset_o_err: got %b, required 0", bus.o_err); end
    n_checks++; if (bus.o_address !== '0) begin n_errors++; $display("FAIL reset_o_address: got %h, required 0", bus.o_address); end
    n_checks++; if (bus.o_wdata !== '0) begin n_errors++; $display("FAIL reset_o_wdata: got %h, required 0", bus.o_wdata); end
    n_checks++; if (bus.o_read_write_enable !== 1'b0) begin n_errors++; $display("FAIL reset_o_rw: got %b, required 0", bus.o_read_write_enable); end
    n_checks++; if (bus.o_flit_ready !== 1'b1) begin n_errors++; $display("FAIL reset_o_flit_ready: got %b, required 1", bus.o_flit_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_decode_basic();
    req_t exp;
    pkt[0] = 16'hABCE; pkt[1] = 16'h1235; pkt[2] = 16'h5679; pkt[3] = 16'h8001;
    exp = model_decode();
    bus.i_ready = 1'b1;
    got_q.delete(); err_cycles = 0;
    send_pkt(1'b0);
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL basic_latency: o_valid=%b one cycle after tail, required 1", bus.o_valid); end
    n_checks++; if (bus.o_address !== 14'h2AF3) begin n_errors++; $display("FAIL basic_address: got %h, required 2af3", bus.o_address); end
    n_checks++; if (bus.o_read_write_enable !== 1'b1) begin n_errors++; $display("FAIL basic_rw: got %b, required 1", bus.o_read_write_enable); end
    n_checks++; if (bus.o_wdata !== exp.wdata) begin n_errors++; $display("FAIL basic_wdata: got %h, required %h", bus.o_wdata, exp.wdata); end
    tick(3);
    check_one_req("basic", exp);
    n_checks++; if (err_cycles != 0) begin n_errors++; $display("FAIL basic_no_err: got %0d error cycles, required 0", err_cycles); end
  endtask

  task automatic test_backpressure();
    req_t exp;
    pkt[0] = 16'hABCE; pkt[1] = 16'h1235; pkt[2] = 16'h5679; pkt[3] = 16'h8001;
    exp = model_decode();
    bus.i_ready = 1'b0;
    got_q.delete();
    send_pkt(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_flit_ready !== 1'b0 ||
          {bus.o_address, bus.o_wdata, bus.o_read_write_enable} !== exp) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: valid=%b ready=%b addr=%h wdata=%h rw=%b, required valid=1 ready=0 addr=%h wdata=%h rw=%b",
                 c, bus.o_valid, bus.o_flit_ready, bus.o_address, bus.o_wdata, bus.o_read_write_enable,
                 exp.addr, exp.wdata, exp.rw);
      end
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release_valid: got %b, required 0", bus.o_valid); end
    n_checks++; if (bus.o_flit_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release_ready: got %b, required 1", bus.o_flit_ready); end
    tick(1);
    check_one_req("stall", exp);
  endtask

  task automatic test_short_packet();
    req_t exp;
    bus.i_ready = 1'b1;
    got_q.delete(); err_cycles = 0;
    send_flit(T_HEAD, FW'($urandom));
    send_flit(T_BODY, FW'($urandom));
    send_flit(T_BODY, FW'($urandom));
    send_flit(T_TAIL, FW'($urandom));
    tick(3);
    n_checks++; if (err_cycles != 1) begin n_errors++; $display("FAIL short_err: got %0d error cycles, required 1", err_cycles); end
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("FAIL short_no_valid: got %0d requests, required 0", got_q.size()); end
    rand_pkt(); exp = model_decode();
    send_pkt(1'b0);
    tick(3);
    check_one_req("short_recover", exp);
  endtask

  task automatic test_resync();
    req_t exp;
    bus.i_ready = 1'b1;
    got_q.delete(); err_cycles = 0;
    send_flit(T_HEAD, FW'($urandom));
    send_flit(T_BODY, FW'($urandom));
    send_flit(T_BODY, FW'($urandom));
    rand_pkt(); exp = model_decode();
    send_pkt(1'b0);
    tick(3);
    n_checks++; if (err_cycles != 1) begin n_errors++; $display("FAIL resync_err: got %0d error cycles, required 1", err_cycles); end
    check_one_req("resync", exp);
  endtask

  task automatic test_protocol_errors();
    req_t exp;
    bus.i_ready = 1'b1;
    got_q.delete(); err_cycles = 0;
    send_flit(T_BODY, FW'($urandom));
    send_flit(T_TAIL, FW'($urandom));
    send_flit(T_RSVD, FW'($urandom));
    send_flit(T_HEAD, FW'($urandom));
    for (int k = 0; k < NB + 1; k++) send_flit(T_BODY, FW'($urandom));
    send_flit(T_HEAD, FW'($urandom));
    send_flit(T_BODY, FW'($urandom));
    send_flit(T_RSVD, FW'($urandom));
    tick(3);
    n_checks++; if (err_cycles != 5) begin n_errors++; $display("FAIL proto_err: got %0d error cycles, required 5", err_cycles); end
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("FAIL proto_no_valid: got %0d requests, required 0", got_q.size()); end
    rand_pkt(); exp = model_decode();
    send_pkt(1'b0);
    tick(3);
    check_one_req("proto_recover", exp);
  endtask

  task automatic test_reset_mid();
    req_t exp;
    bus.i_ready = 1'b1;
    got_q.delete(); err_cycles = 0;
    send_flit(T_HEAD, FW'($urandom));
    for (int k = 0; k < 3; k++) send_flit(T_BODY, FW'($urandom));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0 || bus.o_address !== '0 || bus.o_wdata !== '0 ||
        bus.o_read_write_enable !== 1'b0 || bus.o_flit_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pkt: valid=%b err=%b addr=%h wdata=%h rw=%b ready=%b, required 0 0 0 0 0 1",
               bus.o_valid, bus.o_err, bus.o_address, bus.o_wdata, bus.o_read_write_enable, bus.o_flit_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_ready = 1'b0;
    rand_pkt();
    send_pkt(1'b0);
    tick(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_wdata !== '0 || bus.o_flit_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_output: valid=%b wdata=%h ready=%b, required 0 0 1", bus.o_valid, bus.o_wdata, bus.o_flit_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    rand_pkt(); exp = model_decode();
    send_pkt(1'b0);
    tick(3);
    n_checks++; if (err_cycles != 0) begin n_errors++; $display("FAIL rst_no_err: got %0d error cycles, required 0", err_cycles); end
    check_one_req("rst_recover", exp);
  endtask

  task automatic test_random_stream();
    bit done;
    done = 1'b0;
    got_q.delete(); exp_q.delete(); err_cycles = 0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          rand_pkt();
          exp_q.push_back(model_decode());
          send_pkt(1'b0);
          if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.i_ready = 1'b1;
    tick(4);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL random_count: got %0d requests, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL random_req_%0d: got addr=%h wdata=%h rw=%b, required addr=%h wdata=%h rw=%b",
                 i, got_q[i].addr, got_q[i].wdata, got_q[i].rw, exp_q[i].addr, exp_q[i].wdata, exp_q[i].rw);
      end
    end
    n_checks++; if (err_cycles != 0) begin n_errors++; $display("FAIL random_no_err: got %0d error cycles, required 0", err_cycles); end
  endtask

`ifdef FLIT_PKT_DECODER_PARITY_EN
  task automatic test_parity();
    req_t exp;
    bus.i_ready = 1'b1;
    pkt[0] = 16'hABCE; pkt[1] = 16'h1235; pkt[2] = 16'h5679; pkt[3] = 16'h8001;
    exp = model_decode();
    got_q.delete(); err_cycles = 0;
    send_pkt(1'b1);
    tick(3);
    n_checks++; if (err_cycles != 1) begin n_errors++; $display("FAIL parity_bad_err: got %0d error cycles, required 1", err_cycles); end
    n_checks++; if (got_q.size() != 0) begin n_errors++; $display("FAIL parity_bad_valid: got %0d requests, required 0", got_q.size()); end
    send_pkt(1'b0);
    tick(3);
    check_one_req("parity_good", exp);
  endtask
`endif

  initial begin
    test_reset();
    test_decode_basic();
    test_backpressure();
    test_short_packet();
    test_resync();
    test_protocol_errors();
    test_reset_mid();
    test_random_stream();
`ifdef FLIT_PKT_DECODER_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
